mtm_alu_core: RTL and testbench
===============================

# mtm_Alu_core

Arithmetic stage of the serial ALU. It sits between `mtm_Alu_deserializer`, which delivers operands, opcode and receive-error flags, and `mtm_Alu_serializer`, which transmits the result. Per accepted command it executes the operation, derives the status flags and computes a bit-serial CRC3. It then holds a complete response word until the serializer accepts it.

## Interface
- No parameters; widths fixed by the frame protocol.
- `clk` in 1: single clock, posedge active.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: one-cycle pulse, qualifies the inputs below.
- `A_in` in 32: operand A.
- `B_in` in 32: operand B.
- `op_in` in 3: opcode (AND 000, OR 001, ADD 100, SUB 101).
- `err_flg_in` in 6: receive errors from the deserializer (ERR_DATA 100100, ERR_CRC 010010, ERR_OP 001001, OR-combined).
- `out_ready` in 1: serializer accepts the response.
- `out_valid` out 1: response held and valid.
- `C_out` out 32: result.
- `flags_out` out 4: {Carry, Overflow, Zero, Negative}.
- `crc_out` out 3: CRC3 of the result word.
- `err_out` out 1: response is an error frame.
- `err_flg_out` out 6: error flags.
- `parity_out` out 1: even parity for the error frame.
- `dropped` out 1: one-cycle pulse when a command is ignored.

## Operation
- FSM states: IDLE, CALC, CRC, HOLD.
- **IDLE**
  - `in_valid` = 1: register the inputs, go to CALC.
- **CALC** (one cycle)
  - `err_flg_in` ≠ 0: `err_out`=1, `err_flg_out`=`err_flg_in`, go to HOLD.
  - `err_flg_in` = 0 and opcode not in {000, 001, 100, 101}: `err_out`=1, `err_flg_out`=001001, go to HOLD.
  - Otherwise: register C and flags, clear the CRC register to 000, go to CRC.
- **Arithmetic** (all 32-bit, wrap-around)
  - ADD: C = B + A; Carry = carry out of bit 31.
  - SUB: C = B − A; Carry = borrow (B < A, unsigned).
  - Overflow = signed overflow for ADD and SUB; Carry = Overflow = 0 for AND and OR.
  - Zero = (C == 0); Negative = C[31].
- **CRC** (37 cycles)
  - Shift in {C[31:0], 1'b0, flags[3:0]}, MSB first. Polynomial x³+x+1, init 000.
  - Per bit d: fb = crc[2]^d; crc = {crc[1], crc[0]^fb, fb}.
  - After the 37th bit, go to HOLD.
- **HOLD**
  - `out_valid`=1 with all response outputs stable.
  - `out_valid` & `out_ready` in the same cycle: go to IDLE; `out_valid` deasserts the next cycle.
- **Error parity**: `parity_out` = ^{1'b1, err_flg_out}; it is 0 when `err_out`=0.
- **Busy drop**: `in_valid` in CALC, CRC or HOLD is ignored, and `dropped` pulses one cycle later. The held response is not disturbed.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0.
- Latency, `in_valid` sampled at edge k:
  - Normal path: `out_valid` rises after edge k+39 (1 CALC + 37 CRC + 1).
  - Error path: `out_valid` rises after edge k+2.
- `out_ready` while `out_valid`=0 is ignored.
- `in_valid` in the same cycle as the HOLD→IDLE handshake is dropped; acceptance is possible only in IDLE.
- `rst_n` low mid-CRC or mid-HOLD aborts immediately. No response is emitted and `dropped` does not pulse.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- `mtm_Alu_pkg`:
  - Opcode enum.
  - ERR_DATA/ERR_CRC/ERR_OP constants.
  - Flag bit indices.
  - CRC3 polynomial and init.
  - CRC input length (37).
- Sub-module `mtm_Alu_crc3`: serial LFSR with `clr`, `en`, `d` inputs and a 3-bit `crc` output. Also reused by the serializer's model.

## Test plan
- **Zero result CRC**: AND, A=0x0F0F0F0F, B=0xF0F0F0F0 -> C=0, flags 0010, crc 110, `out_valid` at k+39.
- **Signed overflow**: ADD, B=0x7FFFFFFF, A=1 -> C=0x80000000, flags 0101, crc matches bench LFSR model.
- **Borrow**: SUB, B=0, A=1 -> C=0xFFFFFFFF, flags 1001.
- **Error paths**:
  - `err_flg_in`=100100 -> err_out=1, err_flg_out=100100, parity 1, `out_valid` at k+2.
  - op=010 with no input errors -> err_flg_out=001001, parity 1.
- **Back-pressure**: `out_ready` held low 100 cycles, second `in_valid` at +50 -> `dropped` pulses, first response unchanged. After `out_ready`, `out_valid` falls the next cycle.
- **Reset mid-operation**: `rst_n` pulsed low during CRC -> all outputs 0, no `out_valid`. A fresh ADD 1+2 afterwards -> C=3, flags 0000.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// ============================================================================
// Module      : mtm_alu_pkg
// Description : Shared types and constants for the serial ALU arithmetic stage
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Low-order coefficients of x^3+x+1; the x^3 term is implicit in the feedback.
  localparam logic [2:0] CRC_POLY = 3'b011;
  localparam logic [2:0] CRC_INIT = 3'b000;
  localparam int         CRC_LEN  = 37;

endpackage

`default_nettype wire

// File: rtl/mtm_alu_crc3.sv
// ============================================================================
// Module      : mtm_alu_crc3
// Description : Bit-serial CRC3 LFSR, MSB first, with synchronous clear
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [2:0] crc
);

  logic [2:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[2] ^ d;
  assign crc  = r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (clr) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= {r_crc[1] ^ (w_fb & CRC_POLY[2]),
                r_crc[0] ^ (w_fb & CRC_POLY[1]),
                w_fb & CRC_POLY[0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mtm_alu_core.sv
// ============================================================================
// Module      : mtm_alu_core
// Description : ALU execute stage: operation, status flags, CRC3, held response
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mtm_alu_core
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic [2:0]  op_in,
  input  logic [5:0]  err_flg_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] C_out,
  output logic [3:0]  flags_out,
  output logic [2:0]  crc_out,
  output logic        err_out,
  output logic [5:0]  err_flg_out,
  output logic        parity_out,
  output logic        dropped
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_CRC  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [5:0] CRC_LAST = 6'(CRC_LEN - 1);

  logic [1:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  op_t         r_op;
  logic [5:0]  r_err_in;
  logic [36:0] r_shift;
  logic [5:0]  r_cnt;

  logic [32:0] w_sum;
  logic [31:0] w_c;
  logic [3:0]  w_flags;
  logic        w_op_ok;

  always_comb begin
    w_sum   = 33'd0;
    w_flags = 4'd0;
    w_op_ok = 1'b1;
    case (r_op)
      OP_AND: w_sum = {1'b0, r_b & r_a};
      OP_OR:  w_sum = {1'b0, r_b | r_a};
      OP_ADD: begin
        w_sum           = {1'b0, r_b} + {1'b0, r_a};
        w_flags[FLAG_C] = w_sum[32];
        w_flags[FLAG_V] = (r_a[31] == r_b[31]) && (w_sum[31] != r_b[31]);
      end
      OP_SUB: begin
        // Bit 32 of the 33-bit difference is the unsigned borrow.
        w_sum           = {1'b0, r_b} - {1'b0, r_a};
        w_flags[FLAG_C] = w_sum[32];
        w_flags[FLAG_V] = (r_a[31] != r_b[31]) && (w_sum[31] != r_b[31]);
      end
      default: w_op_ok = 1'b0;
    endcase
    w_c             = w_sum[31:0];
    w_flags[FLAG_Z] = (w_c == 32'd0);
    w_flags[FLAG_N] = w_c[31];
  end

  mtm_alu_crc3 u_crc3 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_state == S_CALC),
    .en    (r_state == S_CRC),
    .d     (r_shift[36]),
    .crc   (crc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_op        <= OP_AND;
      r_err_in    <= 6'd0;
      r_shift     <= 37'd0;
      r_cnt       <= 6'd0;
      out_valid   <= 1'b0;
      C_out       <= 32'd0;
      flags_out   <= 4'd0;
      err_out     <= 1'b0;
      err_flg_out <= 6'd0;
      parity_out  <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      dropped <= in_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A_in;
            r_b      <= B_in;
            r_op     <= op_t'(op_in);
            r_err_in <= err_flg_in;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_err_in != 6'd0) begin
            err_out     <= 1'b1;
            err_flg_out <= r_err_in;
            parity_out  <= ^{1'b1, r_err_in};
            C_out       <= 32'd0;
            flags_out   <= 4'd0;
            r_state     <= S_HOLD;
          end else if (!w_op_ok) begin
            err_out     <= 1'b1;
            err_flg_out <= ERR_OP;
            parity_out  <= ^{1'b1, ERR_OP};
            C_out       <= 32'd0;
            flags_out   <= 4'd0;
            r_state     <= S_HOLD;
          end else begin
            err_out     <= 1'b0;
            err_flg_out <= 6'd0;
            parity_out  <= 1'b0;
            C_out       <= w_c;
            flags_out   <= w_flags;
            r_shift     <= {w_c, 1'b0, w_flags};
            r_cnt       <= 6'd0;
            r_state     <= S_CRC;
          end
        end
        S_CRC: begin
          r_shift <= {r_shift[35:0], 1'b0};
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == CRC_LAST) begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          // out_valid trails entry into HOLD by one cycle so every field is settled first.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mtm_alu_core.sv
// ============================================================================
// Module      : tb_mtm_alu_core
// Description : Randomized self-checking bench for mtm_alu_core
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mtm_alu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] A_in = 32'd0;
  logic [31:0] B_in = 32'd0;
  logic [2:0]  op_in = 3'd0;
  logic [5:0]  err_flg_in = 6'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] C_out;
  logic [3:0]  flags_out;
  logic [2:0]  crc_out;
  logic        err_out;
  logic [5:0]  err_flg_out;
  logic        parity_out;
  logic        dropped;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  f;
    logic [2:0]  crc;
    logic        err;
    logic [5:0]  ef;
    logic        par;
  } resp_t;

  always #5 clk = ~clk;

  mtm_alu_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .A_in        (A_in),
    .B_in        (B_in),
    .op_in       (op_in),
    .err_flg_in  (err_flg_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .C_out       (C_out),
    .flags_out   (flags_out),
    .crc_out     (crc_out),
    .err_out     (err_out),
    .err_flg_out (err_flg_out),
    .parity_out  (parity_out),
    .dropped     (dropped)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus CRC as polynomial long division.
  function automatic resp_t model(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [5:0] err);
    resp_t          r;
    longint         sa;
    longint         sb;
    longint         sres;
    longint unsigned full;
    logic [39:0]    rem;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    if (err != 6'd0 || !(op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
      r.err = 1'b1;
      r.ef  = (err != 6'd0) ? err : 6'b001001;
      r.par = ($countones(r.ef) % 2 == 0);
      return r;
    end
    case (op)
      3'b000: r.c = a & b;
      3'b001: r.c = a | b;
      3'b100: begin
        full   = longint'(b) + longint'(a);
        r.c    = full[31:0];
        r.f[3] = (full >= 64'h1_0000_0000);
        sres   = sb + sa;
        r.f[2] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      default: begin
        r.c    = b - a;
        r.f[3] = (b < a);
        sres   = sb - sa;
        r.f[2] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
    endcase
    r.f[1] = (r.c == 32'd0);
    r.f[0] = r.c[31];
    rem = {r.c, 1'b0, r.f, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (rem[i]) rem[i -: 4] = rem[i -: 4] ^ 4'b1011;
    end
    r.crc = rem[2:0];
    return r;
  endfunction

  task automatic send(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [5:0] err);
    @(posedge clk); #1;
    A_in = a; B_in = b; op_in = op; err_flg_in = err; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_resp(string tag, resp_t e);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".c"}, C_out, e.c);
    check({tag, ".flags"}, flags_out, e.f);
    check({tag, ".crc"}, crc_out, e.crc);
    check({tag, ".err"}, err_out, e.err);
    check({tag, ".errflg"}, err_flg_out, e.ef);
    check({tag, ".parity"}, parity_out, e.par);
  endtask

  task automatic release_resp(string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".fall"}, out_valid, 1'b0);
  endtask

  task automatic run_cmd(string tag, logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [5:0] err);
    resp_t e;
    int    lat;
    e = model(a, b, op, err);
    send(a, b, op, err);
    wait_valid(lat);
    check({tag, ".lat"}, lat, e.err ? 2 : 39);
    check_resp(tag, e);
    release_resp(tag);
  endtask

  initial begin
    resp_t       e;
    int          lat;
    logic [2:0]  good_ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic [2:0]  bad_ops  [4] = '{3'b010, 3'b011, 3'b110, 3'b111};
    logic [5:0]  errs     [3] = '{6'b100100, 6'b010010, 6'b001001};
    logic        hold_ok;
    logic        seen_valid;
    logic [2:0]  op;
    logic [5:0]  err;

    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 1'b0);
    check("rst.c", C_out, 32'd0);
    check("rst.flags", flags_out, 4'd0);
    check("rst.crc", crc_out, 3'd0);
    check("rst.err", {err_out, err_flg_out, parity_out, dropped}, 9'd0);
    rst_n = 1'b1;

    // Directed corner cases
    run_cmd("zero", 32'h0F0F0F0F, 32'hF0F0F0F0, 3'b000, 6'd0);
    check("zero.crc_const", crc_out, 3'b110);
    run_cmd("ovf", 32'h00000001, 32'h7FFFFFFF, 3'b100, 6'd0);
    run_cmd("borrow", 32'h00000001, 32'h00000000, 3'b101, 6'd0);
    run_cmd("errdata", 32'h12345678, 32'h9ABCDEF0, 3'b100, 6'b100100);
    run_cmd("badop", 32'h1, 32'h2, 3'b010, 6'd0);
    run_cmd("carry", 32'hFFFFFFFF, 32'h00000001, 3'b100, 6'd0);
    run_cmd("subovf", 32'h00000001, 32'h80000000, 3'b101, 6'd0);

    // Randomized commands
    for (int t = 0; t < 25; t++) begin
      op  = good_ops[$urandom_range(0, 3)];
      err = 6'd0;
      if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) err = errs[$urandom_range(0, 2)] | errs[$urandom_range(0, 2)];
      run_cmd($sformatf("rnd%0d", t), $urandom, $urandom, op, err);
    end

    // Back-pressure with a busy drop
    e = model(32'h00000005, 32'h00000007, 3'b101, 6'd0);
    send(32'h00000005, 32'h00000007, 3'b101, 6'd0);
    wait_valid(lat);
    check("bp.lat", lat, 39);
    hold_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 50) begin
        A_in = 32'hDEADBEEF; B_in = 32'hCAFEF00D; op_in = 3'b100; in_valid = 1'b1;
      end
      if (i == 51) begin
        in_valid = 1'b0;
        check("bp.dropped", dropped, 1'b1);
      end
      if (i == 52) check("bp.dropped_end", dropped, 1'b0);
      if (!out_valid) hold_ok = 1'b0;
    end
    check("bp.held", hold_ok, 1'b1);
    check_resp("bp", e);
    release_resp("bp");

    // Reset in the middle of the CRC phase
    send(32'h11111111, 32'h22222222, 3'b100, 6'd0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("amid.valid", out_valid, 1'b0);
    check("amid.c", C_out, 32'd0);
    check("amid.misc", {flags_out, crc_out, err_out, err_flg_out, parity_out, dropped}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid || dropped) seen_valid = 1'b1;
    end
    check("amid.quiet", seen_valid, 1'b0);
    run_cmd("post", 32'd1, 32'd2, 3'b100, 6'd0);
    check("post.c3", C_out, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
